// File: rtl/set_assoc_cache.sv
// 2-way set-associative, write-through / no-write-allocate cache, one word per line.
// A single FSM (IDLE / RD_MEM / WR_MEM) sequences the misses and the write-through.
module set_assoc_cache #(
    parameter int NUM_SETS   = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_R_EN,
    input  logic                  MEM_W_EN,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);
    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDR_WIDTH - INDEX_W - 2;

    typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM} state_t;

    state_t                state_q;
    logic                  mem_rd_en_q, mem_wr_en_q;
    logic [NUM_SETS-1:0]   valid0_q, valid1_q, lru_q;
    logic [TAG_W-1:0]      tag0_q  [NUM_SETS];
    logic [TAG_W-1:0]      tag1_q  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data0_q [NUM_SETS];
    logic [DATA_WIDTH-1:0] data1_q [NUM_SETS];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit0, hit1, hit, hit_way, victim;
    logic               rd_req, wr_req;

    assign idx     = address[INDEX_W+1:2];
    assign tag     = address[ADDR_WIDTH-1:INDEX_W+2];
    assign hit0    = valid0_q[idx] && (tag0_q[idx] == tag);
    assign hit1    = valid1_q[idx] && (tag1_q[idx] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;
    // Fill an empty way first; only fall back to LRU when the set is full.
    assign victim  = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);
    // A simultaneous read and write is treated as a read only.
    assign rd_req  = MEM_R_EN;
    assign wr_req  = MEM_W_EN && !MEM_R_EN;

    assign mem_rd_en = mem_rd_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_addr  = address;
    assign mem_wdata = wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            valid0_q    <= '0;
            valid1_q    <= '0;
            lru_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        valid0_q <= '0;
                        valid1_q <= '0;
                        lru_q    <= '0;
                    end else if (rd_req) begin
                        if (hit) begin
                            lru_q[idx] <= !hit_way;
                        end else begin
                            state_q     <= RD_MEM;
                            mem_rd_en_q <= 1'b1;
                        end
                    end else if (wr_req) begin
                        if (hit) lru_q[idx] <= !hit_way;
                        state_q     <= WR_MEM;
                        mem_wr_en_q <= 1'b1;
                    end
                end
                RD_MEM: begin
                    if (mem_ready) begin
                        if (victim) valid1_q[idx] <= 1'b1;
                        else        valid0_q[idx] <= 1'b1;
                        lru_q[idx]  <= !victim;
                        state_q     <= IDLE;
                        mem_rd_en_q <= 1'b0;
                    end
                end
                WR_MEM: begin
                    if (mem_ready) begin
                        state_q     <= IDLE;
                        mem_wr_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_rd_en_q <= 1'b0;
                    mem_wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data storage carries no reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && !flush && wr_req && hit) begin
            if (hit_way) data1_q[idx] <= wdata;
            else         data0_q[idx] <= wdata;
        end else if (state_q == RD_MEM && mem_ready) begin
            if (victim) begin
                tag1_q[idx]  <= tag;
                data1_q[idx] <= mem_rdata;
            end else begin
                tag0_q[idx]  <= tag;
                data0_q[idx] <= mem_rdata;
            end
        end
    end

    always_comb begin
        ready = 1'b0;
        rdata = '0;
        case (state_q)
            IDLE: begin
                if (!flush && rd_req && hit) begin
                    ready = 1'b1;
                    rdata = hit_way ? data1_q[idx] : data0_q[idx];
                end
            end
            RD_MEM: begin
                ready = mem_ready;
                rdata = mem_rdata;
            end
            WR_MEM: ready = mem_ready;
            default: ready = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: expected data queued at issue, checked on ready.
module tb_set_assoc_cache;
    logic        clk = 1'b0;
    logic        rst, MEM_R_EN, MEM_W_EN, flush, mem_ready;
    logic [31:0] address, wdata, mem_rdata;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        ready, mem_rd_en, mem_wr_en;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    set_assoc_cache #(.NUM_SETS(64), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .address(address), .wdata(wdata), .flush(flush), .rdata(rdata),
        .ready(ready), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Called at posedge+1; returns at posedge+1. lat = cycles mem_rd_en stays high.
    task automatic read_op(input logic [31:0] addr, input logic [31:0] mdata, input int lat,
                           input bit exp_hit, input logic [31:0] exp_data, input int flush_cyc);
        int          cyc = 0;
        int          rd_cnt = 0;
        bit          done = 0;
        bit          addr_bad = 0;
        bit          wr_seen = 0;
        logic [31:0] e;
        exp_q.push_back(exp_data);
        address = addr; MEM_R_EN = 1'b1; mem_rdata = mdata;
        while (!done && cyc < 50) begin
            flush = (cyc == flush_cyc);
            if (mem_rd_en) begin
                rd_cnt++;
                mem_ready = (rd_cnt >= lat);
                if (mem_addr !== addr) addr_bad = 1;
            end else mem_ready = 1'b0;
            if (mem_wr_en) wr_seen = 1;
            #4;
            if (ready) begin
                e = exp_q.pop_front();
                n_tests++;
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL rdata addr=%h got=%h exp=%h", addr, rdata, e);
                end
                done = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        MEM_R_EN = 1'b0; mem_ready = 1'b0; flush = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL read_timeout addr=%h got=no_ready exp=ready", addr);
            exp_q.delete();
        end
        n_tests++;
        if (rd_cnt !== (exp_hit ? 0 : lat)) begin
            n_fail++;
            $display("FAIL read_hitmiss addr=%h got_rd_cycles=%0d exp=%0d", addr, rd_cnt, exp_hit ? 0 : lat);
        end
        n_tests++;
        if (addr_bad || wr_seen) begin
            n_fail++;
            $display("FAIL read_strobes addr=%h got_addr_bad=%0d wr_seen=%0d exp=0,0", addr, addr_bad, wr_seen);
        end
    endtask

    task automatic write_op(input logic [31:0] addr, input logic [31:0] data, input int lat);
        int          cyc = 0;
        int          wr_cnt = 0;
        bit          done = 0;
        bit          bad = 0;
        logic [31:0] e;
        exp_q.push_back(data);
        address = addr; wdata = data; MEM_W_EN = 1'b1;
        while (!done && cyc < 50) begin
            if (mem_wr_en) begin
                wr_cnt++;
                mem_ready = (wr_cnt >= lat);
                if (mem_addr !== addr) bad = 1;
            end else mem_ready = 1'b0;
            if (mem_rd_en) bad = 1;
            #4;
            if (ready) begin
                e = exp_q.pop_front();
                n_tests++;
                if (mem_wdata !== e || mem_wr_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mem_wdata addr=%h got=%h wr_en=%b exp=%h wr_en=1", addr, mem_wdata, mem_wr_en, e);
                end
                done = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        MEM_W_EN = 1'b0; mem_ready = 1'b0;
        n_tests++;
        if (!done || wr_cnt != lat || bad) begin
            n_fail++;
            $display("FAIL write addr=%h got_done=%0d wr_cycles=%0d bad=%0d exp=1,%0d,0", addr, done, wr_cnt, bad, lat);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; MEM_R_EN = 0; MEM_W_EN = 0; flush = 0; mem_ready = 0;
        address = '0; wdata = '0; mem_rdata = '0;
        #12;
        n_tests++;
        if (ready !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b%b%b exp=000", ready, mem_rd_en, mem_wr_en);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_fill();
        read_op(32'h100, 32'hDEADBEEF, 3, 0, 32'hDEADBEEF, -1);
        read_op(32'h100, 32'h0, 3, 1, 32'hDEADBEEF, -1);
    endtask

    task automatic test_lru_evict();
        read_op(32'h1100, 32'h11110000, 1, 0, 32'h11110000, -1);
        read_op(32'h100,  32'h0,        1, 1, 32'hDEADBEEF, -1);
        read_op(32'h2100, 32'h22220000, 2, 0, 32'h22220000, -1);
        read_op(32'h100,  32'h0,        1, 1, 32'hDEADBEEF, -1);
        read_op(32'h1100, 32'h11110001, 1, 0, 32'h11110001, -1);
    endtask

    task automatic test_write_hit();
        write_op(32'h100, 32'h12345678, 2);
        read_op(32'h100, 32'h0, 1, 1, 32'h12345678, -1);
    endtask

    task automatic test_write_miss();
        write_op(32'h3000, 32'h0000A5A5, 1);
        read_op(32'h3000, 32'h30303030, 1, 0, 32'h30303030, -1);
    endtask

    task automatic test_flush();
        address = 32'h100; MEM_R_EN = 1'b1; flush = 1'b1;
        #4;
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready got=%b exp=0", ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; MEM_R_EN = 1'b0;
        read_op(32'h100,  32'h0F0F0100, 2, 0, 32'h0F0F0100, -1);
        read_op(32'h3000, 32'h0F0F3000, 1, 0, 32'h0F0F3000, -1);
        // flush pulsed while the fill is outstanding must not disturb anything
        read_op(32'h4004, 32'h44440004, 3, 0, 32'h44440004, 1);
        read_op(32'h4004, 32'h0, 1, 1, 32'h44440004, -1);
        read_op(32'h100,  32'h0, 1, 1, 32'h0F0F0100, -1);
    endtask

    task automatic test_back_to_back();
        int rdy_cnt = 0;
        int rd_cnt = 0;
        address = 32'h4004; MEM_R_EN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (mem_rd_en) rd_cnt++;
            #4;
            if (ready && rdata === 32'h44440004) rdy_cnt++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (rdy_cnt != 2 || rd_cnt != 0) begin
            n_fail++;
            $display("FAIL back_to_back got_ready=%0d rd=%0d exp=2,0", rdy_cnt, rd_cnt);
        end
        MEM_W_EN = 1'b1; wdata = 32'hFFFFFFFF;
        #4;
        n_tests++;
        if (ready !== 1'b1 || rdata !== 32'h44440004) begin
            n_fail++;
            $display("FAIL rd_wr_both got=%b/%h exp=1/44440004", ready, rdata);
        end
        @(posedge clk); #1;
        n_tests++;
        if (mem_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_wr_both_wr_en got=%b exp=0", mem_wr_en);
        end
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        read_op(32'h4004, 32'h0, 1, 1, 32'h44440004, -1);
    endtask

    task automatic test_reset_abort();
        address = 32'h208; MEM_R_EN = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (mem_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre got=%b exp=1", mem_rd_en);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_tests++;
        if (mem_rd_en !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_now got=%b%b exp=00", mem_rd_en, ready);
        end
        MEM_R_EN = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        read_op(32'h208, 32'h0BADF00D, 1, 0, 32'h0BADF00D, -1);
    endtask

    initial begin
        test_reset();
        test_read_fill();
        test_lru_evict();
        test_write_hit();
        test_write_miss();
        test_flush();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
